mux_scan: RTL and testbench

MUX_SCAN -- requirements
Module: mux_scan

---
 rtl/mux_scan.sv | 123 ++++++++++++
 tb/tb_mux_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and auto-scan (dwell per channel).
// Optional registered even-parity output out_par when MUX_SCAN_PARITY_EN is defined.
module mux_scan #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned DWELL = 4,
  localparam int unsigned SEL_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      out,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid
`ifdef MUX_SCAN_PARITY_EN
  ,output logic             out_par
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MANUAL = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [SEL_W-1:0] scan_ch, scan_ch_nxt, cur_ch, mux_idx, out_ch_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt, cur_dwell;
  logic [W-1:0]     mux_data, out_nxt;
  logic             idx_ok, out_valid_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus next datapath values; outputs follow the state being entered
  always_comb begin
    state_nxt     = state;
    scan_ch_nxt   = scan_ch;
    dwell_nxt     = dwell_cnt;
    out_nxt       = out;
    out_ch_nxt    = out_ch;
    out_valid_nxt = 1'b0;
    cur_ch        = scan_ch;
    cur_dwell     = dwell_cnt;
    mux_idx       = sel;
    mux_data      = '0;
    idx_ok        = 1'b0;

    case (state)
      IDLE, MANUAL, SCAN: begin
        if (!en)       state_nxt = IDLE;
        else if (mode) state_nxt = SCAN;
        else           state_nxt = MANUAL;
      end
      default: state_nxt = IDLE;
    endcase

    // Any entry into SCAN restarts the sweep at channel 0, dwell 0
    if (state != SCAN) begin
      cur_ch    = '0;
      cur_dwell = '0;
    end
    if (state_nxt == SCAN) mux_idx = cur_ch;

    for (int unsigned k = 0; k < N_CH; k++) begin
      if (mux_idx == SEL_W'(k)) begin
        mux_data = in_data[k*W +: W];
        idx_ok   = 1'b1;
      end
    end

    case (state_nxt)
      MANUAL: begin
        out_nxt       = idx_ok ? mux_data : '0;
        out_ch_nxt    = sel;
        out_valid_nxt = idx_ok;
      end
      SCAN: begin
        out_nxt       = mux_data;
        out_ch_nxt    = cur_ch;
        out_valid_nxt = 1'b1;
        if (cur_dwell == CNT_W'(DWELL - 1)) begin
          dwell_nxt   = '0;
          scan_ch_nxt = (cur_ch == SEL_W'(N_CH - 1)) ? '0 : cur_ch + SEL_W'(1);
        end else begin
          dwell_nxt   = cur_dwell + CNT_W'(1);
          scan_ch_nxt = cur_ch;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      scan_ch   <= '0;
      dwell_cnt <= '0;
    end else begin
      out       <= out_nxt;
      out_ch    <= out_ch_nxt;
      out_valid <= out_valid_nxt;
      scan_ch   <= scan_ch_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_par <= 1'b0;
    else        out_par <= ^out_nxt;
  end
`endif

endmodule

// File: tb/tb_mux_scan.sv
// Scoreboard bench for mux_scan: three instances (4x1 manual, 4x8 scan, 3x8 DWELL=1).
module tb_mux_scan;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  in1;  logic [1:0] sel1; logic mode1, en1;
  logic        o1;   logic [1:0] c1;   logic v1;
  logic [31:0] in2;  logic [1:0] sel2; logic mode2, en2;
  logic [7:0]  o2;   logic [1:0] c2;   logic v2;
`ifdef MUX_SCAN_PARITY_EN
  logic        par2;
`endif
  logic [23:0] in3;  logic [1:0] sel3; logic mode3, en3;
  logic [7:0]  o3;   logic [1:0] c3;   logic v3;

  mux_scan #(.N_CH(4), .W(1), .DWELL(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in1), .sel(sel1), .mode(mode1), .en(en1),
    .out(o1), .out_ch(c1), .out_valid(v1));

  mux_scan #(.N_CH(4), .W(8), .DWELL(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in2), .sel(sel2), .mode(mode2), .en(en2),
    .out(o2), .out_ch(c2), .out_valid(v2)
`ifdef MUX_SCAN_PARITY_EN
    , .out_par(par2)
`endif
  );

  mux_scan #(.N_CH(3), .W(8), .DWELL(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in3), .sel(sel3), .mode(mode3), .en(en3),
    .out(o3), .out_ch(c3), .out_valid(v3));

  typedef struct {
    int         id;
    logic [7:0] o;
    logic [1:0] c;
    logic       v;
    logic       p;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_out(input int id, input logic [7:0] o, input logic [1:0] c,
                            input logic v, input string tag);
    exp_t e;
    e.id = id; e.o = o; e.c = c; e.v = v; e.p = 1'b0; e.tag = tag;
`ifdef MUX_SCAN_PARITY_EN
    if (id == 2) e.p = ^o;
`endif
    q.push_back(e);
  endtask

  task automatic compare_all();
    while (q.size() > 0) begin
      exp_t e;
      logic [7:0] oo;
      logic [1:0] oc;
      logic       ov, op;
      e  = q.pop_front();
      op = 1'b0;
      case (e.id)
        1:       begin oo = {7'b0, o1}; oc = c1; ov = v1; end
        2:       begin oo = o2; oc = c2; ov = v2; end
        default: begin oo = o3; oc = c3; ov = v3; end
      endcase
`ifdef MUX_SCAN_PARITY_EN
      if (e.id == 2) op = par2;
`endif
      checks++;
      assert ({oo, oc, ov, op} === {e.o, e.c, e.v, e.p}) else begin
        errors++;
        $error("FAIL %s dut%0d: observed out=%h ch=%0d valid=%b par=%b, expected out=%h ch=%0d valid=%b par=%b",
               e.tag, e.id, oo, oc, ov, op, e.o, e.c, e.v, e.p);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] bytes2 [4];
    logic [3:0] dv;
    int ch;
    bytes2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    rst_n = 1'b0;
    in1 = '0; sel1 = '0; mode1 = 1'b0; en1 = 1'b0;
    in2 = '0; sel2 = '0; mode2 = 1'b0; en2 = 1'b0;
    in3 = '0; sel3 = '0; mode3 = 1'b0; en3 = 1'b0;

    #3;
    for (int d = 1; d <= 3; d++) expect_out(d, 8'h00, 2'd0, 1'b0, "reset_state");
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Manual sweep on the 4x1 instance
    en1 = 1'b1; mode1 = 1'b0;
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        in1  = 4'(d);
        sel1 = 2'(s);
        dv   = 4'(d);
        expect_out(1, {7'b0, dv[s]}, 2'(s), 1'b1, "manual_sweep");
        tick();
      end
    end
    en1 = 1'b0;
    expect_out(1, 8'h01, 2'd3, 1'b0, "idle_hold");
    tick();

    // Scan with wrap, stopping at channel 2 dwell 1
    in2 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    en2 = 1'b1; mode2 = 1'b1;
    for (int i = 0; i < 26; i++) begin
      ch = (i / 4) % 4;
      expect_out(2, bytes2[ch], 2'(ch), 1'b1, "scan_seq");
      tick();
    end
    mode2 = 1'b0; sel2 = 2'd1;
    expect_out(2, 8'hB2, 2'd1, 1'b1, "scan_to_manual");
    tick();

    // Back to scan: restart at ch0 with full dwell, data follows live input
    mode2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ch = i / 4;
      if (i == 2) in2[7:0] = 8'h5A;
      if (i == 3) in2[7:0] = 8'hA1;
      expect_out(2, (i == 2) ? 8'h5A : bytes2[ch], 2'(ch), 1'b1, "rescan");
      tick();
    end

    // Asynchronous reset between edges mid-scan
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 1; d <= 3; d++) expect_out(d, 8'h00, 2'd0, 1'b0, "async_reset");
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch = i / 4;
      expect_out(2, bytes2[ch], 2'(ch), 1'b1, "post_reset_scan");
      tick();
    end

    // N_CH=3: out-of-range select, then DWELL=1 scan
    in3 = {8'h33, 8'h22, 8'h11};
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3;
    expect_out(3, 8'h00, 2'd3, 1'b0, "sel_oob");
    tick();
    sel3 = 2'd2;
    expect_out(3, 8'h33, 2'd2, 1'b1, "sel_last");
    tick();
    mode3 = 1'b1;
    expect_out(3, 8'h11, 2'd0, 1'b1, "dwell1_ch0"); tick();
    expect_out(3, 8'h22, 2'd1, 1'b1, "dwell1_ch1"); tick();
    expect_out(3, 8'h33, 2'd2, 1'b1, "dwell1_ch2"); tick();
    expect_out(3, 8'h11, 2'd0, 1'b1, "dwell1_wrap"); tick();
    en3 = 1'b0; mode3 = 1'b0;
    expect_out(3, 8'h11, 2'd0, 1'b0, "en_priority"); tick();
    expect_out(3, 8'h11, 2'd0, 1'b0, "idle_hold3"); tick();
    en3 = 1'b1; mode3 = 1'b1;
    expect_out(3, 8'h11, 2'd0, 1'b1, "reentry_ch0"); tick();
    expect_out(3, 8'h22, 2'd1, 1'b1, "reentry_ch1"); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
